// File: rtl/color_file_pn_if.sv
// CPU-side memory bus into the colour file: address, write data and an
// active-low write strobe in; combinational read data and address hit out.
interface color_file_pn_if;
  logic [15:0] I_MEMBUS_ADDR;
  logic [7:0]  I_DATA;
  logic        I_MEMBUS_WE_L;
  logic [7:0]  O_DATA;
  logic        O_IS_CF_ADDR;

  modport master (
    output I_MEMBUS_ADDR, I_DATA, I_MEMBUS_WE_L,
    input  O_DATA, O_IS_CF_ADDR
  );

  modport slave (
    input  I_MEMBUS_ADDR, I_DATA, I_MEMBUS_WE_L,
    output O_DATA, O_IS_CF_ADDR
  );
endinterface

// File: rtl/color_file_pn.sv
// Multi-channel palette colour file (GBC palette RAM successor).
// Each channel has a spec/data register pair on the CPU bus and a registered
// colour lookup port for the PPU. After reset an init sequencer fills every
// entry of every channel with INIT_COLOR, then raises O_READY.
// Optional build macro: CF_MODE3_LOCK_EN -- blocks data register reads and
// stores while the PPU is in pixel transfer (auto-increment still advances).
module color_file_pn #(
  parameter int          N_CH       = 2,
  parameter int          N_PAL      = 8,
  parameter int          N_COL      = 4,
  parameter logic [15:0] BASE_ADDR  = 16'hFF68,
  parameter logic [15:0] INIT_COLOR = 16'h7FFF,
  localparam int         PAL_W      = $clog2(N_PAL),
  localparam int         COL_W      = $clog2(N_COL),
  localparam int         IDX_W      = PAL_W + COL_W + 1
) (
  input  logic                    I_CLK,
  input  logic                    I_RESET,
  color_file_pn_if.slave          bus,
  input  logic                    I_PPU_MODE3,
  input  logic [N_CH*PAL_W-1:0]   I_PAL_SEL,
  input  logic [N_CH*COL_W-1:0]   I_PAL_INDEX,
  output logic [N_CH*16-1:0]      O_PAL_COLOR,
  output logic                    O_READY
);
  localparam int ENT_W = PAL_W + COL_W;
  localparam int NBYTE = 1 << IDX_W;
  localparam logic [ENT_W-1:0] ENT_LAST = ENT_W'(N_PAL * N_COL - 1);
  localparam logic [ENT_W-1:0] ENT_ONE  = ENT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t           state_q;
  logic [ENT_W-1:0] cnt_q;
  logic             ready_q;
  logic             in_init;

  logic [15:0]           off;
  logic                  is_cf;
  logic                  we;
  logic                  lock;
  logic [N_CH-1:0]       spec_hit, data_hit;
  logic [N_CH-1:0][7:0]  spec_rd, data_rd;
  logic [7:0]            rd_data;

  assign in_init = (state_q == S_INIT);
  assign O_READY = ready_q;

  // Register window decode: 2*N_CH consecutive addresses from BASE_ADDR.
  assign off   = bus.I_MEMBUS_ADDR - BASE_ADDR;
  assign is_cf = (off < 16'(2 * N_CH));
  assign we    = ~bus.I_MEMBUS_WE_L;

`ifdef CF_MODE3_LOCK_EN
  assign lock = I_PPU_MODE3;
`else
  // Mode 3 has no effect in this build; the port is kept for pin compatibility.
  logic unused_mode3;
  assign lock         = 1'b0;
  assign unused_mode3 = I_PPU_MODE3;
`endif

  // Init sequencer: one entry per cycle across all channels, then park in RUN.
  always_ff @(posedge I_CLK) begin
    if (I_RESET) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + ENT_ONE;
          if (cnt_q == ENT_LAST) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    localparam logic [15:0] SPEC_OFF = 16'(2 * c);
    localparam logic [15:0] DATA_OFF = 16'(2 * c + 1);

    logic [NBYTE-1:0][7:0] mem_q, mem_d;
    logic                  auto_q, auto_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [15:0]           col_q, col_d;
    logic [ENT_W-1:0]      ent;

    assign spec_hit[c] = is_cf && (off == SPEC_OFF);
    assign data_hit[c] = is_cf && (off == DATA_OFF);
    assign ent         = {I_PAL_SEL[c*PAL_W +: PAL_W], I_PAL_INDEX[c*COL_W +: COL_W]};

    // Bit6 always reads 1; bits between the index and bit6 read 0.
    assign spec_rd[c] = 8'h40 | {auto_q, 7'b0} | 8'(idx_q);
    assign data_rd[c] = lock ? 8'hFF : mem_q[idx_q];

    assign O_PAL_COLOR[c*16 +: 16] = col_q;

    // Next-state for the channel array, index/auto-inc register and PPU port.
    // The PPU reads mem_q, so a same-cycle CPU store is seen one lookup later.
    always_comb begin
      mem_d  = mem_q;
      auto_d = auto_q;
      idx_d  = idx_q;
      col_d  = '0;
      if (in_init) begin
        mem_d[{cnt_q, 1'b0}] = INIT_COLOR[7:0];
        mem_d[{cnt_q, 1'b1}] = INIT_COLOR[15:8];
      end
      if (we && spec_hit[c]) begin
        auto_d = bus.I_DATA[7];
        idx_d  = bus.I_DATA[IDX_W-1:0];
      end
      if (we && data_hit[c]) begin
        if (!in_init && !lock) mem_d[idx_q] = bus.I_DATA;
        if (auto_q) idx_d = idx_q + IDX_ONE;
      end
      if (!in_init) col_d = {mem_q[{ent, 1'b1}], mem_q[{ent, 1'b0}]};
    end

    // Control state with reset.
    always_ff @(posedge I_CLK) begin
      if (I_RESET) begin
        auto_q <= 1'b0;
        idx_q  <= '0;
        col_q  <= '0;
      end else begin
        auto_q <= auto_d;
        idx_q  <= idx_d;
        col_q  <= col_d;
      end
    end

    // Colour storage; contents are established by the init sequencer.
    always_ff @(posedge I_CLK) begin
      mem_q <= mem_d;
    end
  end

  // CPU read mux; unmapped addresses float high.
  always_comb begin
    rd_data = 8'hFF;
    for (int c = 0; c < N_CH; c++) begin
      if (spec_hit[c]) rd_data = spec_rd[c];
      if (data_hit[c]) rd_data = data_rd[c];
    end
  end

  assign bus.O_DATA       = rd_data;
  assign bus.O_IS_CF_ADDR = is_cf;
endmodule

// File: tb/tb_color_file_pn.sv
// Scoreboard bench for color_file_pn: expected values are queued when the
// stimulus is driven and popped when the DUT output is sampled.
module tb_color_file_pn;
  logic        clk = 1'b0;
  logic        rst;
  logic        mode3;
  logic [5:0]  pal_sel;
  logic [3:0]  pal_index;
  logic [31:0] pal_color;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] e;

  color_file_pn_if bus ();

  color_file_pn dut (
    .I_CLK       (clk),
    .I_RESET     (rst),
    .bus         (bus.slave),
    .I_PPU_MODE3 (mode3),
    .I_PAL_SEL   (pal_sel),
    .I_PAL_INDEX (pal_index),
    .O_PAL_COLOR (pal_color),
    .O_READY     (ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    bus.I_MEMBUS_ADDR = a;
    bus.I_DATA        = d;
    bus.I_MEMBUS_WE_L = 1'b0;
    tick();
    bus.I_MEMBUS_WE_L = 1'b1;
  endtask

  // Present a read address and let the combinational read path settle.
  task automatic cpu_addr(input logic [15:0] a, input logic [7:0] exp_byte);
    bus.I_MEMBUS_ADDR = a;
    bus.I_MEMBUS_WE_L = 1'b1;
    exp_q.push_back({8'h00, exp_byte});
    #1;
  endtask

  // Drive both lookup ports and queue the colours expected after one edge.
  task automatic ppu_drive(input logic [2:0] s0, input logic [1:0] i0,
                           input logic [2:0] s1, input logic [1:0] i1,
                           input logic [15:0] c0, input logic [15:0] c1);
    pal_sel   = {s1, s0};
    pal_index = {i1, i0};
    exp_q.push_back(c0);
    exp_q.push_back(c1);
  endtask

  task automatic test_reset;
    int low_cycles;
    rst = 1'b1;
    tick(); tick(); tick();
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b exp 0", ready); end
    n_tests++;
    if (pal_color !== 32'h0) begin n_fail++; $display("FAIL reset_color got %h exp 0", pal_color); end
    cpu_addr(16'hFF68, 8'h40);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL reset_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    rst = 1'b0;
    low_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready !== 1'b1) low_cycles++;
      if (i == 10) begin
        n_tests++;
        if (pal_color !== 32'h0) begin n_fail++; $display("FAIL init_color got %h exp 0", pal_color); end
      end
      tick();
    end
    n_tests++;
    if (low_cycles != 32) begin n_fail++; $display("FAIL init_length got %0d exp 32", low_cycles); end
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL ready_after got %b exp 1", ready); end
    ppu_drive(3'd0, 2'd0, 3'd0, 2'd0, 16'h7FFF, 16'h7FFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL init_lk0 got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL init_lk1 got %h exp %h", pal_color[31:16], e); end
    ppu_drive(3'd5, 2'd3, 3'd7, 2'd2, 16'h7FFF, 16'h7FFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL init_lk2 got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL init_lk3 got %h exp %h", pal_color[31:16], e); end
  endtask

  task automatic test_decode;
    cpu_addr(16'hFF67, 8'hFF);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_IS_CF_ADDR !== 1'b0 || bus.O_DATA !== e[7:0]) begin
      n_fail++; $display("FAIL decode_below hit %b data %h exp 0/%h", bus.O_IS_CF_ADDR, bus.O_DATA, e[7:0]);
    end
    cpu_addr(16'hFF6C, 8'hFF);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_IS_CF_ADDR !== 1'b0 || bus.O_DATA !== e[7:0]) begin
      n_fail++; $display("FAIL decode_above hit %b data %h exp 0/%h", bus.O_IS_CF_ADDR, bus.O_DATA, e[7:0]);
    end
    cpu_addr(16'hFF6B, 8'hFF);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_IS_CF_ADDR !== 1'b1 || bus.O_DATA !== e[7:0]) begin
      n_fail++; $display("FAIL decode_last hit %b data %h exp 1/%h", bus.O_IS_CF_ADDR, bus.O_DATA, e[7:0]);
    end
  endtask

  task automatic test_autoinc;
    cpu_wr(16'hFF68, 8'h80);
    cpu_wr(16'hFF69, 8'h1F);
    cpu_wr(16'hFF69, 8'h00);
    cpu_addr(16'hFF68, 8'hC2);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL autoinc_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    ppu_drive(3'd0, 2'd0, 3'd0, 2'd0, 16'h001F, 16'h7FFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL autoinc_ch0 got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL autoinc_ch1 got %h exp %h", pal_color[31:16], e); end
    cpu_wr(16'hFF68, 8'h80);
    cpu_addr(16'hFF69, 8'h1F);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL autoinc_rd got %h exp %h", bus.O_DATA, e[7:0]); end
  endtask

  task automatic test_wrap;
    cpu_wr(16'hFF6A, 8'hBF);
    cpu_wr(16'hFF6B, 8'hAA);
    cpu_wr(16'hFF6B, 8'h55);
    cpu_addr(16'hFF6A, 8'hC1);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL wrap_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    cpu_addr(16'hFF68, 8'hC0);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL wrap_ch0_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    ppu_drive(3'd0, 2'd0, 3'd7, 2'd3, 16'h001F, 16'hAAFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL wrap_ch0 got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL wrap_e63 got %h exp %h", pal_color[31:16], e); end
    ppu_drive(3'd0, 2'd0, 3'd0, 2'd0, 16'h001F, 16'h7F55); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL wrap_ch0b got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL wrap_e0 got %h exp %h", pal_color[31:16], e); end
  endtask

  task automatic test_noinc;
    cpu_wr(16'hFF68, 8'h04);
    cpu_wr(16'hFF69, 8'h12);
    cpu_wr(16'hFF69, 8'h12);
    cpu_addr(16'hFF68, 8'h44);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL noinc_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    cpu_addr(16'hFF69, 8'h12);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL noinc_data got %h exp %h", bus.O_DATA, e[7:0]); end
    ppu_drive(3'd0, 2'd2, 3'd0, 2'd2, 16'h7F12, 16'h7FFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL noinc_lk got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL noinc_ch1 got %h exp %h", pal_color[31:16], e); end
  endtask

  task automatic test_read_before_write;
    cpu_wr(16'hFF68, 8'h00);
    ppu_drive(3'd0, 2'd0, 3'd0, 2'd0, 16'h001F, 16'h7F55);
    cpu_wr(16'hFF69, 8'hAB);
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL rbw_old got %h exp %h", pal_color[15:0], e); end
    e = exp_q.pop_front();
    exp_q.push_back(16'h00AB);
    tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL rbw_new got %h exp %h", pal_color[15:0], e); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] exp1 [4];
    exp1[0] = 16'h0201; exp1[1] = 16'h0403; exp1[2] = 16'h0605; exp1[3] = 16'h7FFF;
    cpu_wr(16'hFF6A, 8'h90);
    for (int i = 1; i <= 6; i++) cpu_wr(16'hFF6B, 8'(i));
    for (int i = 0; i < 4; i++) begin
      ppu_drive(3'd0, 2'd0, 3'd2, 2'(i), 16'h00AB, exp1[i]);
      tick();
      n_tests++; e = exp_q.pop_front();
      if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL b2b_ch0[%0d] got %h exp %h", i, pal_color[15:0], e); end
      n_tests++; e = exp_q.pop_front();
      if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL b2b_ch1[%0d] got %h exp %h", i, pal_color[31:16], e); end
    end
  endtask

  task automatic test_mode3;
    logic [7:0]  exp_byte;
    logic [15:0] exp_col;
`ifdef CF_MODE3_LOCK_EN
    exp_byte = 8'hFF;
    exp_col  = 16'h00AB;
`else
    exp_byte = 8'h33;
    exp_col  = 16'h0033;
`endif
    mode3 = 1'b1;
    cpu_wr(16'hFF68, 8'h80);
    cpu_wr(16'hFF69, 8'h33);
    cpu_addr(16'hFF68, 8'hC1);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL mode3_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    cpu_wr(16'hFF68, 8'h80);
    cpu_addr(16'hFF69, exp_byte);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL mode3_data got %h exp %h", bus.O_DATA, e[7:0]); end
    mode3 = 1'b0;
    ppu_drive(3'd0, 2'd0, 3'd0, 2'd0, exp_col, 16'h7F55); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL mode3_entry got %h exp %h", pal_color[15:0], e); end
    e = exp_q.pop_front();
  endtask

  task automatic test_reset_mid;
    int k;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (ready !== 1'b0) begin n_fail++; $display("FAIL rerst_ready got %b exp 0", ready); end
    cpu_addr(16'hFF6A, 8'h40);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL rerst_spec got %h exp %h", bus.O_DATA, e[7:0]); end
    cpu_wr(16'hFF68, 8'h80);
    cpu_wr(16'hFF69, 8'h99);
    cpu_addr(16'hFF68, 8'hC1);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL init_wr_inc got %h exp %h", bus.O_DATA, e[7:0]); end
    k = 0;
    while (ready !== 1'b1 && k < 40) begin tick(); k++; end
    n_tests++;
    if (ready !== 1'b1) begin n_fail++; $display("FAIL rerst_timeout got %b exp 1", ready); end
    cpu_wr(16'hFF68, 8'h80);
    cpu_addr(16'hFF69, 8'hFF);
    n_tests++; e = exp_q.pop_front();
    if (bus.O_DATA !== e[7:0]) begin n_fail++; $display("FAIL init_wr_drop got %h exp %h", bus.O_DATA, e[7:0]); end
    ppu_drive(3'd0, 2'd0, 3'd7, 2'd3, 16'h7FFF, 16'h7FFF); tick();
    n_tests++; e = exp_q.pop_front();
    if (pal_color[15:0] !== e) begin n_fail++; $display("FAIL rerst_ch0 got %h exp %h", pal_color[15:0], e); end
    n_tests++; e = exp_q.pop_front();
    if (pal_color[31:16] !== e) begin n_fail++; $display("FAIL rerst_ch1 got %h exp %h", pal_color[31:16], e); end
  endtask

  initial begin
    rst               = 1'b1;
    mode3             = 1'b0;
    pal_sel           = '0;
    pal_index         = '0;
    bus.I_MEMBUS_ADDR = 16'h0000;
    bus.I_DATA        = 8'h00;
    bus.I_MEMBUS_WE_L = 1'b1;
    test_reset();
    test_decode();
    test_autoinc();
    test_wrap();
    test_noinc();
    test_read_before_write();
    test_back_to_back();
    test_mode3();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
